// File: rtl/pingpong_ctrl.sv
// Ping-pong buffer controller: alternates two external memory banks between a writer
// and a reader. Each bank is handed over whole, either when filled or flushed early.
module pingpong_ctrl #(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic                  wr_flush,
   output logic                  sl_din,
   output logic                  we1,
   output logic                  we2,
   output logic [ADDR_WIDTH-1:0] waddr,
   input  logic                  rd_ready,
   output logic                  sl_dout,
   output logic                  re,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic [1:0]            bank_full
);

   localparam int LEN_W = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   logic                  r_slDin;
   logic                  r_slDout;
   logic [ADDR_WIDTH-1:0] r_wcnt;
   logic [ADDR_WIDTH-1:0] r_rcnt;
   logic [1:0]            r_full;
   logic [LEN_W-1:0]      r_len1;
   logic [LEN_W-1:0]      r_len2;
   logic                  r_rdValid;
   logic                  r_rdLast;

   logic                  w_wrBankFull;
   logic                  w_rdBankFull;
   logic                  w_accept;
   logic                  w_close;
   logic [LEN_W-1:0]      w_closeLen;
   logic [LEN_W-1:0]      w_rdLen;
   logic                  w_rdLastWord;
   logic                  w_release;
   logic [1:0]            w_fullNext;

   // Bank1 maps to full bit 0 and is selected when a select line is 1.
   always_comb begin
      w_wrBankFull = r_slDin  ? r_full[0] : r_full[1];
      w_rdBankFull = r_slDout ? r_full[0] : r_full[1];
      w_rdLen      = r_slDout ? r_len1    : r_len2;

      wr_ready = ~w_wrBankFull;
      w_accept = wr_valid & wr_ready & ~rst;
      we1      = w_accept & r_slDin;
      we2      = w_accept & ~r_slDin;
      waddr    = r_wcnt;

      // A flush closes the bank only if it would hold at least one word.
      w_closeLen = {1'b0, r_wcnt} + {{ADDR_WIDTH{1'b0}}, w_accept};
      w_close    = (w_accept & (r_wcnt == LAST_ADDR))
                 | (wr_flush & ~rst & ((r_wcnt != '0) | w_accept));

      re           = w_rdBankFull & rd_ready & ~rst;
      raddr        = r_rcnt;
      w_rdLastWord = ({1'b0, r_rcnt} == (w_rdLen - LEN_W'(1)));
      w_release    = re & w_rdLastWord;

      w_fullNext = r_full;
      if (w_release) w_fullNext[~r_slDout] = 1'b0;
      if (w_close)   w_fullNext[~r_slDin]  = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_slDin   <= 1'b1;
         r_slDout  <= 1'b1;
         r_wcnt    <= '0;
         r_rcnt    <= '0;
         r_full    <= 2'b00;
         r_len1    <= '0;
         r_len2    <= '0;
         r_rdValid <= 1'b0;
         r_rdLast  <= 1'b0;
      end else begin
         if (w_close) begin
            r_wcnt  <= '0;
            r_slDin <= ~r_slDin;
            if (r_slDin) r_len1 <= w_closeLen;
            else         r_len2 <= w_closeLen;
         end else if (w_accept) begin
            r_wcnt <= r_wcnt + ADDR_WIDTH'(1);
         end

         if (re) begin
            if (w_rdLastWord) begin
               r_rcnt   <= '0;
               r_slDout <= ~r_slDout;
            end else begin
               r_rcnt <= r_rcnt + ADDR_WIDTH'(1);
            end
         end

         r_full    <= w_fullNext;
         r_rdValid <= re;
         r_rdLast  <= w_release;
      end
   end

   assign sl_din    = r_slDin;
   assign sl_dout   = r_slDout;
   assign bank_full = r_full;
   assign rd_valid  = r_rdValid;
   assign rd_last   = r_rdLast;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Testbench for pingpong_ctrl: directed scenarios followed by random traffic, all
// compared against a queue-of-closed-banks reference model.
module tb_pingpong_ctrl;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_valid;
   logic          wr_ready;
   logic          wr_flush;
   logic          sl_din;
   logic          we1;
   logic          we2;
   logic [AW-1:0] waddr;
   logic          rd_ready;
   logic          sl_dout;
   logic          re;
   logic [AW-1:0] raddr;
   logic          rd_valid;
   logic          rd_last;
   logic [1:0]    bank_full;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: closed banks wait in a FIFO (bank id, word count) for the reader.
   bit mWrBank;
   bit mRdBank;
   int mWcnt;
   int mRcnt;
   int qBank[$];
   int qLen[$];
   bit mRdValid;
   bit mRdLast;

   always #5 clk = ~clk;

   pingpong_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_flush(wr_flush), .sl_din(sl_din), .we1(we1), .we2(we2), .waddr(waddr),
      .rd_ready(rd_ready), .sl_dout(sl_dout), .re(re), .raddr(raddr),
      .rd_valid(rd_valid), .rd_last(rd_last), .bank_full(bank_full)
   );

   function automatic logic [15:0] packObs();
      return {2'b00, wr_ready, sl_din, we1, we2, waddr, sl_dout, re, raddr,
              rd_valid, rd_last, bank_full};
   endfunction

   task automatic modelReset();
      mWrBank  = 1'b1;
      mRdBank  = 1'b1;
      mWcnt    = 0;
      mRcnt    = 0;
      qBank.delete();
      qLen.delete();
      mRdValid = 1'b0;
      mRdLast  = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: drive, compare against the model, then advance the model.
   task automatic applyStimulus(input string tag, input bit rs, input bit wv, input bit fl, input bit rr);
      bit          expReady;
      bit          expAccept;
      bit          expRe;
      logic [1:0]  expFull;
      logic [15:0] exp;
      @(negedge clk);
      rst      = rs;
      wr_valid = wv;
      wr_flush = fl;
      rd_ready = rr;
      #1;
      expReady  = (qLen.size() < 2);
      expAccept = wv && expReady && !rs;
      expRe     = (qLen.size() > 0) && rr && !rs;
      expFull   = 2'b00;
      foreach (qBank[i]) expFull[(qBank[i] == 1) ? 0 : 1] = 1'b1;
      exp = {2'b00, expReady, mWrBank, expAccept && mWrBank, expAccept && !mWrBank,
             AW'(mWcnt), mRdBank, expRe, AW'(mRcnt), mRdValid, mRdLast, expFull};
      checkOutput(tag, packObs(), exp);

      if (rs) begin
         modelReset();
      end else begin
         mRdValid = expRe;
         mRdLast  = expRe && (mRcnt == qLen[0] - 1);
         if (expRe) begin
            if (mRcnt == qLen[0] - 1) begin
               void'(qLen.pop_front());
               void'(qBank.pop_front());
               mRcnt   = 0;
               mRdBank = !mRdBank;
            end else begin
               mRcnt++;
            end
         end
         if (expAccept) mWcnt++;
         if (mWcnt == DEPTH || (fl && mWcnt > 0)) begin
            qBank.push_back(mWrBank ? 1 : 2);
            qLen.push_back(mWcnt);
            mWcnt   = 0;
            mWrBank = !mWrBank;
         end
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rrBias;
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_flush = 1'b0;
      rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      modelReset();
      applyStimulus("reset", 1, 0, 0, 0);

      // Fill bank1 with the reader idle.
      for (int i = 0; i < 4; i++) applyStimulus("fill_b1", 0, 1, 0, 0);
      settle();
      checkOutput("b1_full", {14'b0, bank_full}, 16'b01);
      checkOutput("b1_seldin", {15'b0, sl_din}, 16'b0);
      checkOutput("b1_ready", {15'b0, wr_ready}, 16'b1);

      // Fill bank2, then the writer must stall.
      for (int i = 0; i < 4; i++) applyStimulus("fill_b2", 0, 1, 0, 0);
      for (int i = 0; i < 2; i++) applyStimulus("stall", 0, 1, 0, 0);
      checkOutput("both_full", {14'b0, bank_full}, 16'b11);
      checkOutput("stall_ready", {15'b0, wr_ready}, 16'b0);

      // Drain both banks.
      for (int i = 0; i < 9; i++) applyStimulus("drain", 0, 0, 0, 1);
      checkOutput("drained", {14'b0, bank_full}, 16'b00);

      // Partial bank via flush, then a flush on an empty bank.
      for (int i = 0; i < 2; i++) applyStimulus("part_wr", 0, 1, 0, 0);
      applyStimulus("flush", 0, 0, 1, 0);
      applyStimulus("flush_empty", 0, 0, 1, 0);
      settle();
      checkOutput("flush_full", {14'b0, bank_full}, 16'b01);
      checkOutput("flush_seldin", {15'b0, sl_din}, 16'b0);
      for (int i = 0; i < 4; i++) applyStimulus("part_rd", 0, 0, 0, 1);

      // Bank1 release coincides with bank2 close.
      applyStimulus("reset2", 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus("ov_fill", 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus("ov_both", 0, 1, 0, 1);
      settle();
      checkOutput("ov_full", {14'b0, bank_full}, 16'b10);
      checkOutput("ov_sel", {14'b0, sl_din, sl_dout}, 16'b10);
      applyStimulus("ov_after", 0, 0, 0, 0);

      // Reset in the middle of traffic.
      applyStimulus("reset3", 1, 0, 0, 0);
      applyStimulus("mid_wr", 0, 1, 0, 0);
      applyStimulus("mid_wr", 0, 1, 0, 0);
      applyStimulus("mid_flush", 0, 1, 1, 0);
      applyStimulus("mid_rd", 0, 1, 0, 1);
      applyStimulus("mid_rst", 1, 1, 1, 1);
      settle();
      checkOutput("mid_rst_state", packObs(), 16'b00_1_1_0_0_00_1_0_00_0_0_00);
      applyStimulus("mid_release", 0, 0, 0, 0);

      // Random traffic with a reader speed that changes every 100 cycles.
      for (int i = 0; i < 400; i++) begin
         case (i / 100)
            0:       rrBias = 20;
            1:       rrBias = 50;
            2:       rrBias = 80;
            default: rrBias = 95;
         endcase
         applyStimulus("random",
                       $urandom_range(0, 59) == 0,
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 7) == 0,
                       $urandom_range(0, 99) < rrBias);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pingpong_ctrl.md
PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning words per bank (>=2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning bank address width (2^ADDR_WIDTH >= DEPTH).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port wr_valid  input  1  writer presents a word.
REQ-006 SHALL have port wr_ready  output  1  current write bank can accept a word.
REQ-007 SHALL have port wr_flush  input  1  close current write bank early (partial fill).
REQ-008 SHALL have port sl_din  output  1  write-bank select to input mux; 1 = bank1, 0 = bank2.
REQ-009 SHALL have port we1 / we2  output  1 each  write enables of bank1 / bank2.
REQ-010 SHALL have port waddr  output  ADDR_WIDTH  write address into the selected bank.
REQ-011 SHALL have port rd_ready  input  1  reader can take a word.
REQ-012 SHALL have port sl_dout  output  1  read-bank select to output mux; 1 = bank1, 0 = bank2.
REQ-013 SHALL have port re  output  1  read enable to the selected bank.
REQ-014 SHALL have port raddr  output  ADDR_WIDTH  read address into the selected bank.
REQ-015 SHALL have port rd_valid  output  1  bank read data valid (one cycle after re).
REQ-016 SHALL have port rd_last  output  1  qualifies rd_valid for last word of a bank.
REQ-017 SHALL have port bank_full  output  2  bit0 = bank1 full, bit1 = bank2 full.

Function
REQ-018 SHALL define accept = wr_valid & wr_ready; wr_ready = ~full of bank selected by sl_din (combinational).
REQ-019 SHALL drive we1 = accept & sl_din, we2 = accept & ~sl_din, waddr = write counter wcnt (combinational).
REQ-020 SHALL increment wcnt on accept; on accept with wcnt==DEPTH-1, mark bank full, store len=DEPTH, wcnt<=0, toggle sl_din.
REQ-021 SHALL on wr_flush with wcnt>0: mark bank full, len = wcnt+accept, wcnt<=0, toggle sl_din; same-cycle word is included.
REQ-022 SHALL ignore wr_flush when wcnt==0 and no accept; flush with accept at wcnt==0 closes a 1-word bank.
REQ-023 SHALL store len per bank (ADDR_WIDTH+1 bits) at close time.
REQ-024 SHALL assert re = full[sl_dout] & rd_ready (combinational), raddr = read counter rcnt.
REQ-025 SHALL increment rcnt on re; on re with rcnt==len-1: clear full[sl_dout], rcnt<=0, toggle sl_dout.
REQ-026 SHALL register rd_valid <= re and rd_last <= re & (rcnt==len-1), one-cycle latency.
REQ-027 SHALL make cleared full flag visible next cycle; wr_ready for freed bank rises no earlier than cycle after last re.
REQ-028 SHALL allow bank close (write side) and bank release (read side) in the same cycle on different banks, both taking effect.
REQ-029 SHALL hold wr_ready=0 and stall writer while both banks full; no word dropped or overwritten.
REQ-030 SHALL never let write bank equal read bank while that bank is full.

Reset
REQ-031 SHALL on rst: sl_din=1, sl_dout=1, wcnt=0, rcnt=0, bank_full=2'b00, len=0, rd_valid=0, rd_last=0.
REQ-032 SHALL on rst mid-operation discard all buffered data; rst overrides all same-cycle accept/flush/re.
REQ-033 SHALL hold we1/we2/re low while rst asserted.

Verification (DEPTH=4)
REQ-034 SHALL test: rst, then 4 writes, rd_ready=0 -> we1 on addr 0..3, bank_full=01, sl_din=0, wr_ready=1.
REQ-035 SHALL test: 8 writes, rd_ready=0 -> bank_full=11, wr_ready=0, 9th wr_valid held not accepted.
REQ-036 SHALL test: banks full, rd_ready=1 -> re addr 0..3 sl_dout=1, rd_last on 4th rd_valid, then bank2 addr 0..3.
REQ-037 SHALL test: 2 writes then wr_flush -> len=2, two reads, rd_last on 2nd; flush at wcnt==0 no effect.
REQ-038 SHALL test: bank1 last re same cycle as bank2 last write -> bank_full 01->10, sl_din=1, sl_dout=0.
REQ-039 SHALL test: rst asserted after 3 writes and 1 read -> all outputs at reset values next cycle, no re/we.
